// File: rtl/led_pattern_scheduler_if.sv
// ---------------------------------------------------------------------------
// led_pattern_scheduler_if
// Request/grant/LED bundle between status requesters and the LED scheduler.
//   req_valid   [NUM_REQ]      per-requester request level
//   req_pattern [2*NUM_REQ]    pattern of requester i at [2i+1:2i]
//   led                        LED drive, active high
//   grant_valid                an owner is granted
//   grant_id    [$clog2(N)]    current owner index
//   tick                       one-cycle pattern tick strobe
// master: requester side (drives requests), slave: scheduler side.
// ---------------------------------------------------------------------------
interface led_pattern_scheduler_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]         req_valid;
   logic [2*NUM_REQ-1:0]       req_pattern;
   logic                       led;
   logic                       grant_valid;
   logic [$clog2(NUM_REQ)-1:0] grant_id;
   logic                       tick;

   modport master (
      output req_valid, req_pattern,
      input  led, grant_valid, grant_id, tick
   );

   modport slave (
      input  req_valid, req_pattern,
      output led, grant_valid, grant_id, tick
   );
endinterface

// File: rtl/led_pattern_scheduler.sv
// ---------------------------------------------------------------------------
// led_pattern_scheduler
// Shares one LED between NUM_REQ requesters. Fixed priority (index 0 wins),
// a new grant is held MIN_HOLD_TICKS pattern ticks before it can be released
// or replaced by a lower-priority requester; higher priority always preempts.
// The owner's 2-bit pattern (off/solid/slow/fast) is rendered from a shared
// tick every TICK_DIVIDER clocks.
// Ports:
//   clk   system clock
//   rstn  synchronous active-low reset
//   bus   slave side of led_pattern_scheduler_if (requests in, LED/grant out)
// ---------------------------------------------------------------------------
module led_pattern_scheduler #(
   parameter int NUM_REQ        = 4,
   parameter int TICK_DIVIDER   = 10500000,
   parameter int MIN_HOLD_TICKS = 8
) (
   input logic                    clk,
   input logic                    rstn,
   led_pattern_scheduler_if.slave bus
);
   localparam int ID_W = $clog2(NUM_REQ);
   localparam int TC_W = $clog2(TICK_DIVIDER);
   localparam int HC_W = $clog2(MIN_HOLD_TICKS + 1);

   typedef enum logic [1:0] {IDLE, HOLD, RUN} state_t;

   state_t            r_state;
   logic [TC_W-1:0]   r_tick_cnt;
   logic [2:0]        r_phase;
   logic [HC_W-1:0]   r_hold_cnt;
   logic [1:0]        r_pat;
   logic [ID_W-1:0]   r_grant_id;
   logic              r_led;

   state_t            w_state_nxt;
   logic              w_tick;
   logic              w_any;
   logic [ID_W-1:0]   w_winner;
   logic              w_owner_req;
   logic              w_preempt;
   logic              w_new_grant;
   logic              w_track;
   logic              w_led_nxt;
   logic [1:0]        w_winner_pat;
   logic [1:0]        w_owner_pat;

   assign w_tick = (r_tick_cnt == TC_W'(TICK_DIVIDER - 1));

   // Lowest-index active request wins
   always_comb begin
      w_any    = 1'b0;
      w_winner = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (bus.req_valid[i] && !w_any) begin
            w_any    = 1'b1;
            w_winner = ID_W'(i);
         end
      end
   end

   assign w_owner_req  = bus.req_valid[r_grant_id];
   assign w_winner_pat = bus.req_pattern[{w_winner, 1'b0} +: 2];
   assign w_owner_pat  = bus.req_pattern[{r_grant_id, 1'b0} +: 2];
   assign w_preempt    = (r_state != IDLE) && w_any && (w_winner < r_grant_id);

   always_ff @(posedge clk) begin
      if (!rstn) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Preemption is checked before hold expiry so it wins a same-cycle tick
   always_comb begin
      w_state_nxt = r_state;
      w_new_grant = 1'b0;
      w_track     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_state_nxt = HOLD;
               w_new_grant = 1'b1;
            end
         end
         HOLD: begin
            if (w_preempt) begin
               w_new_grant = 1'b1;
            end else begin
               w_track = w_owner_req;
               if (w_tick && r_hold_cnt == HC_W'(MIN_HOLD_TICKS - 1))
                  w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (w_preempt) begin
               w_state_nxt = HOLD;
               w_new_grant = 1'b1;
            end else if (w_owner_req) begin
               w_track = 1'b1;
            end else if (w_any) begin
               w_state_nxt = HOLD;
               w_new_grant = 1'b1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_led_nxt = 1'b0;
      if (r_state != IDLE) begin
         case (r_pat)
            2'b01:   w_led_nxt = 1'b1;
            2'b10:   w_led_nxt = ~r_phase[2];
            2'b11:   w_led_nxt = ~r_phase[0];
            default: w_led_nxt = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_tick_cnt <= '0;
         r_phase    <= '0;
         r_hold_cnt <= '0;
         r_pat      <= '0;
         r_grant_id <= '0;
         r_led      <= 1'b0;
      end else begin
         r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TC_W'(1);
         r_led      <= w_led_nxt;
         if (w_new_grant) begin
            r_grant_id <= w_winner;
            r_pat      <= w_winner_pat;
            r_phase    <= '0;
            r_hold_cnt <= '0;
         end else begin
            if (w_track) r_pat <= w_owner_pat;
            if (w_tick)  r_phase <= r_phase + 3'd1;
            // Saturating: counts only in HOLD, never wraps back into range
            if (w_tick && r_state == HOLD && r_hold_cnt != '1)
               r_hold_cnt <= r_hold_cnt + HC_W'(1);
         end
      end
   end

   assign bus.led         = r_led;
   assign bus.grant_valid = (r_state != IDLE);
   assign bus.grant_id    = r_grant_id;
   assign bus.tick        = w_tick;
endmodule

// File: tb/tb_led_pattern_scheduler.sv
module tb_led_pattern_scheduler;
   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   tests_run = 0;
   int   failed    = 0;
   int   cyc       = 0;

   led_pattern_scheduler_if #(.NUM_REQ(4)) bus ();

   led_pattern_scheduler #(
      .NUM_REQ(4),
      .TICK_DIVIDER(4),
      .MIN_HOLD_TICKS(3)
   ) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Advance to the k-th falling edge after reset release
   task automatic goto(input int k);
      while (cyc < k) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   // Reset for 3 edges, then release with the given requests applied
   task automatic rst_release(input logic [3:0] v, input logic [7:0] p);
      @(negedge clk);
      rstn = 1'b0;
      bus.req_valid   = '0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      bus.req_valid   = v;
      bus.req_pattern = p;
      cyc = 0;
   endtask

   task automatic test_reset();
      rstn            = 1'b0;
      bus.req_valid   = 4'hF;
      bus.req_pattern = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests_run++;
         if (bus.led !== 1'b0) begin failed++; $display("FAIL reset_led[%0d]: got %b want 0", i, bus.led); end
         tests_run++;
         if (bus.grant_valid !== 1'b0) begin failed++; $display("FAIL reset_gv[%0d]: got %b want 0", i, bus.grant_valid); end
         tests_run++;
         if (bus.grant_id !== 2'd0) begin failed++; $display("FAIL reset_id[%0d]: got %0d want 0", i, bus.grant_id); end
         tests_run++;
         if (bus.tick !== 1'b0) begin failed++; $display("FAIL reset_tick[%0d]: got %b want 0", i, bus.tick); end
      end
   endtask

   task automatic test_pulse_hold();
      rst_release(4'b0010, 8'b00_00_01_00);
      goto(1);
      tests_run++;
      if (bus.grant_valid !== 1'b1) begin failed++; $display("FAIL pulse_gv_n1: got %b want 1", bus.grant_valid); end
      tests_run++;
      if (bus.grant_id !== 2'd1) begin failed++; $display("FAIL pulse_id_n1: got %0d want 1", bus.grant_id); end
      tests_run++;
      if (bus.led !== 1'b0) begin failed++; $display("FAIL pulse_led_n1: got %b want 0", bus.led); end
      bus.req_valid = 4'b0000;
      goto(2);
      tests_run++;
      if (bus.led !== 1'b1) begin failed++; $display("FAIL pulse_led_n2: got %b want 1", bus.led); end
      tests_run++;
      if (bus.tick !== 1'b0) begin failed++; $display("FAIL tick_n2: got %b want 0", bus.tick); end
      goto(3);
      tests_run++;
      if (bus.tick !== 1'b1) begin failed++; $display("FAIL tick_n3: got %b want 1", bus.tick); end
      goto(12);
      tests_run++;
      if (bus.grant_valid !== 1'b1) begin failed++; $display("FAIL pulse_gv_n12: got %b want 1", bus.grant_valid); end
      goto(13);
      tests_run++;
      if (bus.grant_valid !== 1'b0) begin failed++; $display("FAIL pulse_gv_n13: got %b want 0", bus.grant_valid); end
      tests_run++;
      if (bus.led !== 1'b1) begin failed++; $display("FAIL pulse_led_n13: got %b want 1", bus.led); end
      goto(14);
      tests_run++;
      if (bus.led !== 1'b0) begin failed++; $display("FAIL pulse_led_n14: got %b want 0", bus.led); end
      tests_run++;
      if (bus.grant_id !== 2'd1) begin failed++; $display("FAIL pulse_id_keep: got %0d want 1", bus.grant_id); end
   endtask

   task automatic test_fast_then_preempt();
      rst_release(4'b0100, 8'b00_11_00_00);
      goto(4);
      tests_run++;
      if (bus.led !== 1'b1) begin failed++; $display("FAIL fast_led_n4: got %b want 1", bus.led); end
      goto(5);
      tests_run++;
      if (bus.led !== 1'b0) begin failed++; $display("FAIL fast_led_n5: got %b want 0", bus.led); end
      goto(8);
      tests_run++;
      if (bus.led !== 1'b0) begin failed++; $display("FAIL fast_led_n8: got %b want 0", bus.led); end
      goto(9);
      tests_run++;
      if (bus.led !== 1'b1) begin failed++; $display("FAIL fast_led_n9: got %b want 1", bus.led); end
      bus.req_valid   = 4'b0101;
      bus.req_pattern = 8'b00_11_00_10;
      goto(10);
      tests_run++;
      if (bus.grant_id !== 2'd0) begin failed++; $display("FAIL preempt_id_n10: got %0d want 0", bus.grant_id); end
      goto(11);
      tests_run++;
      if (bus.led !== 1'b1) begin failed++; $display("FAIL slow_led_n11: got %b want 1", bus.led); end
      goto(24);
      tests_run++;
      if (bus.led !== 1'b1) begin failed++; $display("FAIL slow_led_n24: got %b want 1", bus.led); end
      goto(25);
      tests_run++;
      if (bus.led !== 1'b0) begin failed++; $display("FAIL slow_led_n25: got %b want 0", bus.led); end
      goto(40);
      tests_run++;
      if (bus.led !== 1'b0) begin failed++; $display("FAIL slow_led_n40: got %b want 0", bus.led); end
      goto(41);
      tests_run++;
      if (bus.led !== 1'b1) begin failed++; $display("FAIL slow_led_n41: got %b want 1", bus.led); end
   endtask

   task automatic test_no_low_preempt();
      rst_release(4'b0001, 8'b01_00_00_01);
      goto(13);
      bus.req_valid = 4'b1001;
      goto(14);
      tests_run++;
      if (bus.grant_id !== 2'd0) begin failed++; $display("FAIL lowreq_id_n14: got %0d want 0", bus.grant_id); end
      goto(16);
      bus.req_valid = 4'b1000;
      goto(17);
      tests_run++;
      if (bus.grant_id !== 2'd3) begin failed++; $display("FAIL handover_id_n17: got %0d want 3", bus.grant_id); end
      tests_run++;
      if (bus.grant_valid !== 1'b1) begin failed++; $display("FAIL handover_gv_n17: got %b want 1", bus.grant_valid); end
      bus.req_valid = 4'b0000;
      goto(28);
      tests_run++;
      if (bus.grant_valid !== 1'b1) begin failed++; $display("FAIL handover_hold_n28: got %b want 1", bus.grant_valid); end
      goto(29);
      tests_run++;
      if (bus.grant_valid !== 1'b0) begin failed++; $display("FAIL handover_idle_n29: got %b want 0", bus.grant_valid); end
   endtask

   task automatic test_preempt_on_expiry();
      rst_release(4'b0010, 8'b00_00_01_01);
      goto(11);
      bus.req_valid = 4'b0011;
      goto(12);
      tests_run++;
      if (bus.grant_id !== 2'd0) begin failed++; $display("FAIL expiry_id_n12: got %0d want 0", bus.grant_id); end
      bus.req_valid = 4'b0010;
      goto(13);
      tests_run++;
      if (bus.grant_id !== 2'd0) begin failed++; $display("FAIL expiry_hold_n13: got %0d want 0", bus.grant_id); end
      goto(24);
      tests_run++;
      if (bus.grant_id !== 2'd0) begin failed++; $display("FAIL expiry_hold_n24: got %0d want 0", bus.grant_id); end
      goto(25);
      tests_run++;
      if (bus.grant_id !== 2'd1) begin failed++; $display("FAIL expiry_release_n25: got %0d want 1", bus.grant_id); end
   endtask

   task automatic test_mid_reset();
      rst_release(4'b0100, 8'b00_11_00_00);
      goto(2);
      tests_run++;
      if (bus.led !== 1'b1) begin failed++; $display("FAIL midrst_led_n2: got %b want 1", bus.led); end
      goto(3);
      rstn = 1'b0;
      goto(4);
      tests_run++;
      if (bus.led !== 1'b0) begin failed++; $display("FAIL midrst_led_n4: got %b want 0", bus.led); end
      tests_run++;
      if (bus.grant_valid !== 1'b0) begin failed++; $display("FAIL midrst_gv_n4: got %b want 0", bus.grant_valid); end
      tests_run++;
      if (bus.grant_id !== 2'd0) begin failed++; $display("FAIL midrst_id_n4: got %0d want 0", bus.grant_id); end
      rstn = 1'b1;
      goto(5);
      tests_run++;
      if (bus.grant_valid !== 1'b1) begin failed++; $display("FAIL midrst_gv_n5: got %b want 1", bus.grant_valid); end
      tests_run++;
      if (bus.grant_id !== 2'd2) begin failed++; $display("FAIL midrst_id_n5: got %0d want 2", bus.grant_id); end
      goto(6);
      tests_run++;
      if (bus.led !== 1'b1) begin failed++; $display("FAIL midrst_led_n6: got %b want 1", bus.led); end
   endtask

   initial begin
      test_reset();
      test_pulse_hold();
      test_fast_then_preempt();
      test_no_low_preempt();
      test_preempt_on_expiry();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end
endmodule
